// File: rtl/blob_merge_resolver.sv
// blob_merge_resolver: end-of-frame union-find over label-merge pairs that folds blob stats into roots
// and streams one record per root. Define BLOB_MERGE_MINSIZE_EN to drop roots with npix < MIN_NPIX.
module blob_merge_resolver #(
  parameter int LABEL_W  = 11,
  parameter int NPIX_W   = 19,
  parameter int COORD_W  = 10,
  parameter int MIN_NPIX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] label_max,
  input  logic [LABEL_W-1:0] pair_count,
  output logic [LABEL_W-1:0] pair_addr,
  input  logic [LABEL_W-1:0] pair_l1,
  input  logic [LABEL_W-1:0] pair_l2,
  output logic [LABEL_W-1:0] stat_addr,
  output logic               stat_wr,
  input  logic [NPIX_W-1:0]  stat_npix_i,
  input  logic [COORD_W-1:0] stat_x0_i,
  input  logic [COORD_W-1:0] stat_y0_i,
  input  logic [COORD_W-1:0] stat_xn_i,
  input  logic [COORD_W-1:0] stat_yn_i,
  output logic [NPIX_W-1:0]  stat_npix_o,
  output logic [COORD_W-1:0] stat_x0_o,
  output logic [COORD_W-1:0] stat_y0_o,
  output logic [COORD_W-1:0] stat_xn_o,
  output logic [COORD_W-1:0] stat_yn_o,
  output logic               busy,
  output logic               done,
  output logic               blob_valid,
  input  logic               blob_ready,
  output logic [LABEL_W-1:0] blob_label,
  output logic [NPIX_W-1:0]  blob_npix,
  output logic [COORD_W-1:0] blob_x0,
  output logic [COORD_W-1:0] blob_y0,
  output logic [COORD_W-1:0] blob_xn,
  output logic [COORD_W-1:0] blob_yn,
  output logic [LABEL_W-1:0] blob_count
);

`ifdef BLOB_MERGE_MINSIZE_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif
  localparam logic [LABEL_W-1:0] FIRST_LABEL = LABEL_W'(2);
  localparam logic [LABEL_W-1:0] FIRST_PAIR  = LABEL_W'(1);

  typedef enum logic [3:0] {
    IDLE, INIT, PAIR_RD, PAIR_WAIT, FIND_A, FIND_B, LINK,
    ACC_SCAN, ACC_RDL, ACC_RDR, ACC_WR, EMIT_SCAN, EMIT_RD, EMIT_OUT, DONE
  } state_t;

  state_t             state;
  logic [LABEL_W-1:0] parent [2**LABEL_W];
  logic [LABEL_W-1:0] idx, pidx, cur, lb, ra;
  logic [NPIX_W-1:0]  l_npix;
  logic [COORD_W-1:0] l_x0, l_y0, l_xn, l_yn;
  logic [LABEL_W-1:0] par_cur, par_idx, par_wa, par_wd;
  logic               par_we, pair_skip, last_pair, last_label, too_small;
  logic [NPIX_W:0]    npix_sum;

  assign par_cur    = parent[cur];
  assign par_idx    = parent[idx];
  assign last_pair  = (pidx == pair_count);
  assign last_label = (idx == label_max);
  assign npix_sum   = {1'b0, l_npix} + {1'b0, stat_npix_i};
  assign too_small  = MIN_EN && (stat_npix_i < NPIX_W'(MIN_NPIX));
  assign pair_skip  = (pair_l1 < FIRST_LABEL) || (pair_l2 < FIRST_LABEL) ||
                      (pair_l1 > label_max) || (pair_l2 > label_max) || (pair_l1 == pair_l2);

  // In LINK, cur holds the root of l2 and ra the root of l1; the larger root hangs off the smaller.
  always_comb begin
    par_we = 1'b0;
    par_wa = idx;
    par_wd = idx;
    case (state)
      INIT:    par_we = 1'b1;
      LINK: begin
        par_we = (ra != cur);
        par_wa = (ra > cur) ? ra : cur;
        par_wd = (ra > cur) ? cur : ra;
      end
      ACC_WR: begin
        par_we = 1'b1;
        par_wd = cur;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (par_we) parent[par_wa] <= par_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0; pidx <= '0; cur <= '0; lb <= '0; ra <= '0;
      l_npix <= '0; l_x0 <= '0; l_y0 <= '0; l_xn <= '0; l_yn <= '0;
      pair_addr <= '0; stat_addr <= '0; stat_wr <= 1'b0;
      stat_npix_o <= '0; stat_x0_o <= '0; stat_y0_o <= '0; stat_xn_o <= '0; stat_yn_o <= '0;
      busy <= 1'b0; done <= 1'b0; blob_valid <= 1'b0; blob_count <= '0;
      blob_label <= '0; blob_npix <= '0; blob_x0 <= '0; blob_y0 <= '0; blob_xn <= '0; blob_yn <= '0;
    end else begin
      stat_wr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1; blob_count <= '0; idx <= '0; state <= INIT;
        end
        INIT: if (!last_label) idx <= idx + 1'b1;
          else if (label_max < FIRST_LABEL) begin busy <= 1'b0; done <= 1'b1; state <= DONE; end
          else if (pair_count == '0) begin idx <= FIRST_LABEL; cur <= FIRST_LABEL; state <= ACC_SCAN; end
          else begin pidx <= FIRST_PAIR; pair_addr <= FIRST_PAIR; state <= PAIR_RD; end
        PAIR_RD: state <= PAIR_WAIT;
        PAIR_WAIT: if (!pair_skip) begin cur <= pair_l1; lb <= pair_l2; state <= FIND_A; end
          else if (last_pair) begin idx <= FIRST_LABEL; cur <= FIRST_LABEL; state <= ACC_SCAN; end
          else begin pidx <= pidx + 1'b1; pair_addr <= pidx + 1'b1; state <= PAIR_RD; end
        FIND_A: if (par_cur == cur) begin ra <= cur; cur <= lb; state <= FIND_B; end
          else cur <= par_cur;
        FIND_B: if (par_cur == cur) state <= LINK;
          else cur <= par_cur;
        LINK: if (last_pair) begin idx <= FIRST_LABEL; cur <= FIRST_LABEL; state <= ACC_SCAN; end
          else begin pidx <= pidx + 1'b1; pair_addr <= pidx + 1'b1; state <= PAIR_RD; end
        ACC_SCAN: if (par_cur != cur) cur <= par_cur;
          else if (cur != idx) begin stat_addr <= idx; state <= ACC_RDL; end
          else if (last_label) begin idx <= FIRST_LABEL; state <= EMIT_SCAN; end
          else begin idx <= idx + 1'b1; cur <= idx + 1'b1; end
        ACC_RDL: begin stat_addr <= cur; state <= ACC_RDR; end
        ACC_RDR: begin
          l_npix <= stat_npix_i; l_x0 <= stat_x0_i; l_y0 <= stat_y0_i;
          l_xn <= stat_xn_i; l_yn <= stat_yn_i; state <= ACC_WR;
        end
        ACC_WR: begin
          // stat_addr still points at the root, so the write lands the cycle after this one.
          stat_wr     <= 1'b1;
          stat_npix_o <= npix_sum[NPIX_W] ? '1 : npix_sum[NPIX_W-1:0];
          stat_x0_o   <= (l_x0 < stat_x0_i) ? l_x0 : stat_x0_i;
          stat_y0_o   <= (l_y0 < stat_y0_i) ? l_y0 : stat_y0_i;
          stat_xn_o   <= (l_xn > stat_xn_i) ? l_xn : stat_xn_i;
          stat_yn_o   <= (l_yn > stat_yn_i) ? l_yn : stat_yn_i;
          if (last_label) begin idx <= FIRST_LABEL; state <= EMIT_SCAN; end
          else begin idx <= idx + 1'b1; cur <= idx + 1'b1; state <= ACC_SCAN; end
        end
        EMIT_SCAN: if (par_idx == idx) begin stat_addr <= idx; state <= EMIT_RD; end
          else if (last_label) begin busy <= 1'b0; done <= 1'b1; state <= DONE; end
          else idx <= idx + 1'b1;
        EMIT_RD: state <= EMIT_OUT;
        EMIT_OUT: begin
          if (!blob_valid && !too_small) begin
            blob_valid <= 1'b1; blob_label <= idx; blob_npix <= stat_npix_i;
            blob_x0 <= stat_x0_i; blob_y0 <= stat_y0_i; blob_xn <= stat_xn_i; blob_yn <= stat_yn_i;
          end else if (!blob_valid || blob_ready) begin
            if (blob_valid) begin blob_valid <= 1'b0; blob_count <= blob_count + 1'b1; end
            if (last_label) begin busy <= 1'b0; done <= 1'b1; state <= DONE; end
            else begin idx <= idx + 1'b1; state <= EMIT_SCAN; end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
